img_mem_arbiter: RTL and testbench

- Shares the single-port image RAM (8-bit grayscale pixels, 18-bit address, image data after the 53-byte file header) between two requesters.
- Requester 1 is the VGA pixel fetch path, which has absolute priority. Requester 2 is a pixel writer (loader or processing core) with a valid/ready handshake.
- Writer requests are buffered in a small FIFO and drained only on cycles when video does not request.
- Sits between the video generator, the writer, and the RAM instance.

---
 rtl/img_mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_img_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_mem_arbiter.sv
// Image RAM arbiter: video reads win every cycle; buffered pixel writes drain in idle slots.
// Optional: define ARB_BOUNDS_CHECK_EN to drop writes outside the pixel region (adds bounds_err).
module img_mem_arbiter #(
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned HDR_OFFSET = 53,
    parameter int unsigned N          = 400
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        vid_req,
    input  logic [ADDR_W-1:0]           vid_addr,
    output logic [DATA_W-1:0]           vid_q,
    output logic                        vid_valid,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_we,
    input  logic [DATA_W-1:0]           mem_q,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        wr_done
`ifdef ARB_BOUNDS_CHECK_EN
    ,
    output logic                        bounds_err
`endif
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (HDR_OFFSET + N * N > (1 << ADDR_W)) begin : gen_bad_region
        $error("pixel region does not fit in the RAM address space");
    end

    typedef enum logic [1:0] {
        StIdle,
        StGntVid,
        StGntWr
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                rd_s2_q, rd_s2_d;
    logic                vid_valid_q, vid_valid_d;
    logic [DATA_W-1:0]   pix_q, pix_d;
    logic                wr_done_q, wr_done_d;

    logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];

    logic                wr_fire;
    logic                push;
    logic                pop;

    // Ready looks only at the registered count, so a pop never re-opens it in the same cycle.
    assign wr_ready = rst_n & (count_q < DepthCnt);
    assign wr_fire  = wr_valid & wr_ready;
    assign pop      = ~vid_req & (count_q != '0);

`ifdef ARB_BOUNDS_CHECK_EN
    localparam logic [ADDR_W-1:0] PixLo = ADDR_W'(HDR_OFFSET);
    localparam logic [ADDR_W-1:0] PixHi = ADDR_W'(HDR_OFFSET + N * N - 1);

    logic in_bounds;
    logic bounds_err_q, bounds_err_d;

    assign in_bounds    = (wr_addr >= PixLo) && (wr_addr <= PixHi);
    assign push         = wr_fire & in_bounds;
    assign bounds_err_d = wr_fire & ~in_bounds;
    assign bounds_err   = bounds_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bounds_err_q <= 1'b0;
        end else begin
            bounds_err_q <= bounds_err_d;
        end
    end
`else
    assign push = wr_fire;
`endif

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;

        if (vid_req) begin
            state_d    = StGntVid;
            mem_addr_d = vid_addr;
        end else if (count_q != '0) begin
            state_d     = StGntWr;
            mem_addr_d  = fifo_addr_q[rd_ptr_q];
            mem_wdata_d = fifo_data_q[rd_ptr_q];
        end else begin
            state_d = StIdle;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // A grant to video at edge t puts read data on mem_q during t+1..t+2.
        rd_s2_d     = (state_q == StGntVid);
        vid_valid_d = rd_s2_q;
        pix_d       = rd_s2_q ? mem_q : pix_q;
        wr_done_d   = (state_q == StGntWr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_s2_q     <= 1'b0;
            vid_valid_q <= 1'b0;
            pix_q       <= '0;
            wr_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_s2_q     <= rd_s2_d;
            vid_valid_q <= vid_valid_d;
            pix_q       <= pix_d;
            wr_done_q   <= wr_done_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= wr_addr;
            fifo_data_q[wr_ptr_q] <= wr_data;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = (state_q == StGntWr);
    assign vid_q      = pix_q;
    assign vid_valid  = vid_valid_q;
    assign wr_done    = wr_done_q;
    assign fifo_level = count_q;

endmodule

// File: tb/tb_img_mem_arbiter.sv
// Scoreboard bench for img_mem_arbiter: stimulus queues expected reads/writes, a negedge
// monitor pops and compares them whenever the DUT presents vid_valid or mem_we.
module tb_img_mem_arbiter;

    localparam int AW = 18;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic [DW-1:0] vid_q;
    logic          vid_valid;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_q = '0;
    logic [2:0]    fifo_level;
    logic          wr_done;
`ifdef ARB_BOUNDS_CHECK_EN
    logic          bounds_err;
`endif

    img_mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_q     (vid_q),
        .vid_valid (vid_valid),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_q     (mem_q),
        .fifo_level(fifo_level),
        .wr_done   (wr_done)
`ifdef ARB_BOUNDS_CHECK_EN
        ,
        .bounds_err(bounds_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            cyc;
    } rd_exp_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            cyc;
    } wr_exp_t;

    rd_exp_t exp_rd[$];
    wr_exp_t exp_wr[$];

    int   n_chk = 0;
    int   n_pass = 0;
    int   n_acc = 0;
    int   cyc = 0;
    logic vid_req_edge = 1'b0;
    logic prev_we = 1'b0;

    logic [DW-1:0] ram [1 << AW];

    function automatic logic [DW-1:0] pix(input int a);
        if (a == 53) return 8'hA5;
        return 8'(a) ^ 8'h3C;
    endfunction

    function automatic bit in_region(input int a);
`ifdef ARB_BOUNDS_CHECK_EN
        return (a >= 53) && (a <= 53 + 160000 - 1);
`else
        return (a >= 0);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Synchronous single-port RAM model, one cycle read latency.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_q <= ram[mem_addr];
        vid_req_edge <= vid_req;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        rd_exp_t er;
        wr_exp_t ew;
        if (rst_n) begin
            if (vid_valid) begin
                if (exp_rd.size() == 0) begin
                    check("unexpected_vid_valid", 32'(vid_valid), 32'd0);
                end else begin
                    er = exp_rd.pop_front();
                    check("rd_data", 32'(vid_q), 32'(er.d));
                    check("rd_cycle", cyc, er.cyc);
                end
            end
            if (mem_we) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_mem_we", 32'(mem_we), 32'd0);
                end else begin
                    ew = exp_wr.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(ew.a));
                    check("wr_data", 32'(mem_wdata), 32'(ew.d));
                    if (ew.cyc > 0) check("wr_cycle", cyc, ew.cyc);
                end
                check("wr_in_video_slot", 32'(vid_req_edge), 32'd0);
            end
            if (wr_done || prev_we) check("wr_done", 32'(wr_done), 32'(prev_we));
            prev_we = mem_we;
        end else begin
            prev_we = 1'b0;
        end
    end

    // One cycle of stimulus; wlat > 0 pins the cycle the write must reach the RAM.
    task automatic step(input logic vr, input int va, input logic wv, input int wa,
                        input int wd, input int wlat);
        @(posedge clk);
        #1;
        vid_req  = vr;
        vid_addr = AW'(va);
        wr_valid = wv;
        wr_addr  = AW'(wa);
        wr_data  = DW'(wd);
        if (vr) exp_rd.push_back('{d: pix(va), cyc: cyc + 3});
        if (wv && wr_ready) begin
            n_acc++;
            if (in_region(wa))
                exp_wr.push_back('{a: AW'(wa), d: DW'(wd), cyc: (wlat > 0) ? cyc + wlat : 0});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 0, 0);
    endtask

    initial begin
        int acc0;
        for (int a = 0; a < (1 << AW); a++) ram[a] = pix(a);

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_vid_q", 32'(vid_q), 32'd0);
        check("rst_vid_valid", 32'(vid_valid), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_wr_done", 32'(wr_done), 32'd0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("wr_ready_after_rst", 32'(wr_ready), 32'd1);

        // Single video read of the first pixel
        step(1'b1, 53, 1'b0, 0, 0, 0);
        idle(1);
        check("rd_mem_addr", 32'(mem_addr), 32'd53);
        check("rd_mem_we", 32'(mem_we), 32'd0);
        idle(4);

        // Two back-to-back writes with video idle
        step(1'b0, 0, 1'b1, 100, 'h11, 2);
        step(1'b0, 0, 1'b1, 101, 'h22, 2);
        idle(1);
        check("lvl_pushpop", 32'(fifo_level), 32'd1);
        idle(1);
        check("lvl_drained", 32'(fifo_level), 32'd0);
        idle(3);

        // Video holds the RAM: FIFO fills to depth, then drains on consecutive cycles
        acc0 = n_acc;
        for (int i = 0; i < 5; i++) step(1'b1, 1000 + i, 1'b1, 200 + i, 'hA0 + i, 0);
        check("full_accepts", n_acc - acc0, 4);
        check("full_wr_ready", 32'(wr_ready), 32'd0);
        check("full_level", 32'(fifo_level), 32'd4);
        for (int i = 0; i < 3; i++) step(1'b1, 1005 + i, 1'b0, 0, 0, 0);
        check("starved_level", 32'(fifo_level), 32'd4);
        check("starved_wr_ready", 32'(wr_ready), 32'd0);
        idle(1);
        for (int j = 0; j < 4; j++) begin
            idle(1);
            check("drain_we", 32'(mem_we), 32'd1);
            check("drain_addr", 32'(mem_addr), 32'(200 + j));
            check("drain_level", 32'(fifo_level), 32'(3 - j));
        end
        idle(1);
        check("drain_done_we", 32'(mem_we), 32'd0);
        check("drain_wr_ready", 32'(wr_ready), 32'd1);
        idle(3);

        // Toggling video requests: writes land only in the gaps
        step(1'b1, 2000, 1'b1, 300, 'h33, 4);
        step(1'b1, 2001, 1'b1, 301, 'h44, 5);
        step(1'b1, 2002, 1'b0, 0, 0, 0);
        step(1'b0, 0, 1'b0, 0, 0, 0);
        step(1'b1, 2004, 1'b0, 0, 0, 0);
        idle(7);

        // Reset with queued writes and reads in flight
        step(1'b0, 0, 1'b1, 400, 'h55, 0);
        step(1'b1, 3001, 1'b1, 401, 'h66, 0);
        step(1'b1, 3002, 1'b1, 402, 'h77, 0);
        @(posedge clk);
        #1;
        check("pre_rst_level", 32'(fifo_level), 32'd3);
        rst_n    = 1'b0;
        vid_req  = 1'b0;
        wr_valid = 1'b0;
        exp_rd.delete();
        exp_wr.delete();
        #1;
        check("async_rst_level", 32'(fifo_level), 32'd0);
        check("async_rst_wr_ready", 32'(wr_ready), 32'd0);
        check("async_rst_mem_we", 32'(mem_we), 32'd0);
        check("async_rst_vid_valid", 32'(vid_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(8);
        check("post_rst_level", 32'(fifo_level), 32'd0);

`ifdef ARB_BOUNDS_CHECK_EN
        // Out-of-region writes complete the handshake but never reach the RAM
        step(1'b0, 0, 1'b1, 52, 'h01, 0);
        idle(1);
        check("bounds_err_low", 32'(bounds_err), 32'd1);
        check("bounds_low_level", 32'(fifo_level), 32'd0);
        step(1'b0, 0, 1'b1, 53 + 160000, 'h02, 0);
        idle(1);
        check("bounds_err_high", 32'(bounds_err), 32'd1);
        idle(1);
        check("bounds_err_pulse", 32'(bounds_err), 32'd0);
        step(1'b0, 0, 1'b1, 160052, 'h03, 2);
        idle(5);
`endif

        idle(4);
        check("rd_queue_empty", exp_rd.size(), 0);
        check("wr_queue_empty", exp_wr.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
